// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction-fetch responder between the PC stage, instruction memory and decode
module imem_fetch_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        stall_pc,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t state;
    logic [15:0] cnt;
    logic drop;
    logic expired;
    assign expired = cnt >= LAST;
    assign req_ready = state == IDLE && !drop;
    assign stall_pc = ~req_ready;
    // fetch sequencing: accept, read memory, hold the word for decode, drain discarded reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            drop <= 1'b0;
            mem_req <= 1'b0;
            mem_addr <= '0;
            instr_valid <= 1'b0;
            instr <= '0;
            instr_pc <= '0;
            instr_fault <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop) begin
                        if (mem_rvalid || expired) begin
                            drop <= 1'b0;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else if (req_valid && !flush) begin
                        instr_pc <= req_addr;
                        if (|req_addr[1:0]) begin
                            state <= HOLD;
                            instr <= NOP_WORD;
                            instr_fault <= 1'b1;
                            instr_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            mem_addr <= req_addr;
                            mem_req <= 1'b1;
                            cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= mem_rvalid ? IDLE : DRAIN;
                        cnt <= mem_rvalid ? '0 : cnt + 16'd1;
                    end else if (mem_rvalid) begin
                        state <= HOLD;
                        instr <= mem_rdata;
                        instr_fault <= 1'b0;
                        instr_valid <= 1'b1;
                        cnt <= '0;
                    end else if (expired) begin
                        state <= HOLD;
                        instr <= NOP_WORD;
                        instr_fault <= 1'b1;
                        instr_valid <= 1'b1;
                        drop <= 1'b1;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (mem_rvalid) drop <= 1'b0;
                    if (flush || instr_ready) begin
                        state <= IDLE;
                        instr_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid || expired) begin
                        state <= IDLE;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed fetch scenarios checked against a transaction-level model
module tb_imem_fetch_responder;
    localparam int T = 8;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clk = 1'b0;
    logic reset, req_valid, req_ready, stall_pc, flush, mem_req, mem_rvalid;
    logic instr_valid, instr_ready, instr_fault;
    logic [31:0] req_addr, mem_addr, mem_rdata, instr, instr_pc;
    int compared = 0;
    int mismatched = 0;
    bit fetching, holding, discarding, late, e_valid, e_fault, e_mem_req;
    int age, idle_age;
    logic [31:0] e_instr, e_pc, e_mem_addr;

    imem_fetch_responder #(.TIMEOUT_CYCLES(T), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .stall_pc(stall_pc), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        chk32(n, {31'd0, a}, {31'd0, e});
    endtask

    function automatic logic e_ready();
        return !(fetching || holding || discarding || late);
    endfunction

    task automatic model_reset();
        {fetching, holding, discarding, late, e_valid, e_fault, e_mem_req} = '0;
        age = 0;
        idle_age = 0;
        e_instr = '0;
        e_pc = '0;
        e_mem_addr = '0;
    endtask

    task automatic respond(input logic [31:0] w, input bit f);
        holding = 1;
        e_valid = 1;
        e_instr = w;
        e_fault = f;
    endtask

    // Model: one outstanding fetch; a timed-out read leaves one late response owed
    task automatic model_update();
        e_mem_req = 0;
        if (holding) begin
            if (mem_rvalid) late = 0;
            if (flush || instr_ready) begin
                holding = 0;
                e_valid = 0;
            end
        end else if (fetching) begin
            age++;
            if (flush) begin
                fetching = 0;
                discarding = !mem_rvalid;
            end else if (mem_rvalid) begin
                fetching = 0;
                respond(mem_rdata, 0);
            end else if (age == T) begin
                fetching = 0;
                late = 1;
                idle_age = 0;
                respond(NOP, 1);
            end
        end else if (discarding) begin
            age++;
            if (mem_rvalid || age >= T) discarding = 0;
        end else if (late) begin
            idle_age++;
            if (mem_rvalid || idle_age == T) late = 0;
        end else if (req_valid && !flush) begin
            e_pc = req_addr;
            if (req_addr[1:0] != 2'b00) respond(NOP, 1);
            else begin
                fetching = 1;
                age = 0;
                e_mem_req = 1;
                e_mem_addr = req_addr;
            end
        end
    endtask

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk1("req_ready", req_ready, e_ready());
        chk1("stall_pc", stall_pc, !e_ready());
        chk1("mem_req", mem_req, e_mem_req);
        chk1("instr_valid", instr_valid, e_valid);
        if (fetching) chk32("mem_addr", mem_addr, e_mem_addr);
        if (e_valid) begin
            chk32("instr", instr, e_instr);
            chk32("instr_pc", instr_pc, e_pc);
            chk1("instr_fault", instr_fault, e_fault);
        end
    end

    task automatic step();
        @(posedge clk);
        if (!reset) model_update();
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input int lat, input logic [31:0] d);
        req_valid = 1;
        req_addr = a;
        step();
        req_valid = 0;
        repeat (lat) step();
        mem_rvalid = 1;
        mem_rdata = d;
        step();
        mem_rvalid = 0;
    endtask

    task automatic consume();
        instr_ready = 1;
        step();
        instr_ready = 0;
    endtask

    task automatic chk_reset_values(input string n);
        chk1({n, "_req_ready"}, req_ready, 1'b1);
        chk1({n, "_stall_pc"}, stall_pc, 1'b0);
        chk1({n, "_mem_req"}, mem_req, 1'b0);
        chk32({n, "_mem_addr"}, mem_addr, 32'h0);
        chk1({n, "_instr_valid"}, instr_valid, 1'b0);
        chk32({n, "_instr"}, instr, 32'h0);
        chk32({n, "_instr_pc"}, instr_pc, 32'h0);
        chk1({n, "_instr_fault"}, instr_fault, 1'b0);
    endtask

    initial begin
        reset = 0;
        req_valid = 0;
        req_addr = 0;
        flush = 0;
        mem_rvalid = 0;
        mem_rdata = 0;
        instr_ready = 0;
        model_reset();
        #1 reset = 1;
        #1 chk_reset_values("por");
        #10 reset = 0;
        // aligned fetch, 1-cycle memory latency, then 5 cycles of decode backpressure
        req_valid = 1;
        req_addr = 32'h4;
        step();
        req_valid = 0;
        chk1("s1_mem_req", mem_req, 1'b1);
        chk32("s1_mem_addr", mem_addr, 32'h4);
        chk1("s1_stall", stall_pc, 1'b1);
        step();
        chk1("s1_mem_req_once", mem_req, 1'b0);
        mem_rvalid = 1;
        mem_rdata = 32'h00500093;
        step();
        mem_rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk1("s2_valid", instr_valid, 1'b1);
            chk32("s2_instr", instr, 32'h00500093);
            chk32("s2_pc", instr_pc, 32'h4);
            chk1("s2_fault", instr_fault, 1'b0);
            chk1("s2_stall", stall_pc, 1'b1);
            step();
        end
        consume();
        chk1("s2_valid_drop", instr_valid, 1'b0);
        chk1("s2_idle", req_ready, 1'b1);
        // misaligned fetch
        req_valid = 1;
        req_addr = 32'h6;
        step();
        req_valid = 0;
        chk1("s3_no_mem_req", mem_req, 1'b0);
        chk1("s3_valid", instr_valid, 1'b1);
        chk32("s3_instr", instr, 32'h00000013);
        chk1("s3_fault", instr_fault, 1'b1);
        chk32("s3_pc", instr_pc, 32'h6);
        consume();
        // flush in IDLE ignores the request
        req_valid = 1;
        req_addr = 32'h8;
        flush = 1;
        step();
        req_valid = 0;
        flush = 0;
        chk1("fi_no_mem_req", mem_req, 1'b0);
        chk1("fi_ready", req_ready, 1'b1);
        // flush on WAIT cycle 2, memory latency 4
        req_valid = 1;
        req_addr = 32'h40;
        step();
        req_valid = 0;
        step();
        flush = 1;
        step();
        flush = 0;
        chk1("s4_drain_busy", req_ready, 1'b0);
        step();
        step();
        mem_rvalid = 1;
        mem_rdata = 32'hdeadbeef;
        step();
        mem_rvalid = 0;
        chk1("s4_ready", req_ready, 1'b1);
        chk1("s4_no_valid", instr_valid, 1'b0);
        fetch(32'h100, 1, 32'h00000297);
        chk32("s4_next_instr", instr, 32'h00000297);
        chk32("s4_next_pc", instr_pc, 32'h100);
        consume();
        // flush together with rvalid in WAIT
        req_valid = 1;
        req_addr = 32'h140;
        step();
        req_valid = 0;
        step();
        flush = 1;
        mem_rvalid = 1;
        mem_rdata = 32'h12345678;
        step();
        flush = 0;
        mem_rvalid = 0;
        chk1("fr_ready", req_ready, 1'b1);
        chk1("fr_no_valid", instr_valid, 1'b0);
        // flush in HOLD without instr_ready
        fetch(32'h180, 2, 32'h00c00113);
        chk32("fh_instr", instr, 32'h00c00113);
        flush = 1;
        step();
        flush = 0;
        chk1("fh_valid_drop", instr_valid, 1'b0);
        // timeout, then a late response releases req_ready
        req_valid = 1;
        req_addr = 32'h200;
        step();
        req_valid = 0;
        repeat (T - 1) step();
        chk1("s5_wait", instr_valid, 1'b0);
        step();
        chk1("s5_valid", instr_valid, 1'b1);
        chk32("s5_instr", instr, 32'h00000013);
        chk1("s5_fault", instr_fault, 1'b1);
        chk32("s5_pc", instr_pc, 32'h200);
        consume();
        req_valid = 1;
        req_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            chk1("s5_held", req_ready, 1'b0);
            step();
            chk1("s5_no_mem_req", mem_req, 1'b0);
        end
        req_valid = 0;
        mem_rvalid = 1;
        mem_rdata = 32'h00000bad;
        step();
        mem_rvalid = 0;
        chk1("s5_released", req_ready, 1'b1);
        chk1("s5_late_dropped", instr_valid, 1'b0);
        fetch(32'h304, 1, 32'h00208093);
        chk32("s5_next_instr", instr, 32'h00208093);
        consume();
        // timeout with no late response: released after T idle cycles
        req_valid = 1;
        req_addr = 32'h400;
        step();
        req_valid = 0;
        repeat (T) step();
        chk1("s7_fault", instr_fault, 1'b1);
        consume();
        repeat (T - 1) step();
        chk1("s7_held", req_ready, 1'b0);
        step();
        chk1("s7_released", req_ready, 1'b1);
        // async reset mid-WAIT
        req_valid = 1;
        req_addr = 32'h500;
        step();
        req_valid = 0;
        step();
        #2 reset = 1;
        model_reset();
        #1 chk_reset_values("async");
        @(negedge clk);
        #2 reset = 0;
        fetch(32'h0, 1, 32'h00000517);
        chk1("s6_valid", instr_valid, 1'b1);
        chk32("s6_instr", instr, 32'h00000517);
        chk32("s6_pc", instr_pc, 32'h0);
        chk1("s6_fault", instr_fault, 1'b0);
        consume();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Responder end of the instruction-fetch interface: accepts fetch addresses from the program-counter stage, issues one read to the instruction memory port, and returns the instruction word to decode.
- Handles both ends with valid/ready handshakes. Holds at most one outstanding transaction.
- Drives stall_pc while busy so the PC register holds its value.
- Supports a flush (branch/jump redirect) that discards in-flight fetches. Flags misaligned or timed-out fetches as faults.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waiting for mem_rvalid before a fault response; range 2..65535.
- NOP_WORD, 32'h00000013: instruction returned with a fault (addi x0,x0,0).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  fetch request valid from PC stage
- req_addr  input  32  fetch address (current pc)
- req_ready  output  1  responder can accept a request this cycle
- stall_pc  output  1  hold PC; equals ~req_ready
- flush  input  1  redirect; discard any pending fetch/response
- mem_req  output  1  one-cycle read strobe to instruction memory
- mem_addr  output  32  word-aligned read address
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data
- instr_valid  output  1  instruction available to decode
- instr_ready  input  1  decode consumes instruction
- instr  output  32  instruction word
- instr_pc  output  32  address the instruction was fetched from
- instr_fault  output  1  1 = misaligned or timeout; instr = NOP_WORD

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1, stall_pc=0, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, instr_fault=0, timeout counter=0, drop flag=0.
- States: IDLE, WAIT, HOLD, DRAIN.
- req_ready=1 only in IDLE with drop flag clear; all outputs are registered except req_ready/stall_pc (decoded from state).
- Flush has priority over every other event in every state.
- IDLE:
  - Request accepted when req_valid & req_ready & ~flush. Latch the address into instr_pc.
  - If req_addr[1:0]!=0: go to HOLD next cycle with instr=NOP_WORD, instr_fault=1. No memory access.
  - Otherwise go to WAIT. mem_addr=req_addr, and mem_req=1 for exactly the first WAIT cycle.
  - flush in IDLE: request ignored that cycle.
- WAIT:
  - mem_addr stays stable. Counter increments each WAIT cycle.
  - mem_rvalid (earliest the cycle after mem_req) captures mem_rdata into instr, sets instr_fault=0, and moves to HOLD. Counter clears.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: go to HOLD with instr=NOP_WORD, instr_fault=1, and set the drop flag.
  - flush without rvalid: go to DRAIN.
  - flush with rvalid in the same cycle: data discarded, go to IDLE.
- HOLD:
  - instr_valid=1. instr, instr_pc and instr_fault stay stable until instr_ready.
  - On instr_ready: instr_valid drops next cycle; go to IDLE.
  - flush: instr_valid drops next cycle regardless of instr_ready; go to IDLE.
- DRAIN: wait for mem_rvalid and drop the data. The counter still runs; rvalid or timeout returns to IDLE. instr_valid=0.
- Drop flag (late response after timeout): the next mem_rvalid is ignored and clears the flag. req_ready is held 0 until the flag clears or TIMEOUT_CYCLES elapse in IDLE.
- mem_rvalid arriving in IDLE or HOLD with the drop flag clear is a protocol error and is ignored.
- Latency: request accepted at cycle N, mem_rvalid at N+1+L gives instr_valid at N+2+L. Minimum request-to-instr_valid latency is 3 cycles.
- Throughput: one instruction per 4 cycles minimum; back-to-back acceptance is not required.

Test Plan:
- Aligned fetch, fixed 1-cycle latency: req_addr=0x00000004, mem_rdata=0x00500093 -> mem_req one cycle with mem_addr=0x4. Then instr_valid with instr=0x00500093, instr_pc=0x4, instr_fault=0. stall_pc high from acceptance until instr_ready.
- Decode backpressure: instr_ready held low 5 cycles -> instr/instr_pc stable and instr_valid=1 for all 5 cycles. IDLE entered the cycle after instr_ready=1.
- Misaligned: req_addr=0x00000006 -> no mem_req; instr=0x00000013, instr_fault=1, instr_pc=0x6.
- Flush in WAIT (mem latency 4, flush on WAIT cycle 2) -> DRAIN; returned data dropped; no instr_valid; req_ready=1 the cycle after rvalid. Next fetch 0x100 returns its own data.
- Timeout with TIMEOUT_CYCLES=8, no rvalid -> fault response with NOP at cycle 8 of WAIT. A late rvalid afterwards is dropped, and req_ready stays 0 until it arrives.
- Async reset asserted mid-WAIT -> all outputs are at reset values immediately, without waiting for clk. After release, a fetch of 0x0 completes normally.
